abm_combiner_axi: RTL and testbench

- Read-mostly AXI4 slave over NBANKS simple-dual-port RAM banks.
- Each returned beat is the bitwise combination (OR, AND or XOR) of the same word from every bank.
- Successor to the two-bank OR-only reader: parametrised bank count, RAM latency and combine mode; full-throughput pipelined bursts; RID echo; FIXED bursts; explicit write rejection.
- Sits between the AXI interconnect and the ABM RAM bank array.

---
 rtl/abm_pkg.sv | 26 ++
 rtl/abm_beat_fifo.sv | 53 +++++
 rtl/abm_combiner_axi.sv | 209 ++++++++++++++++++++
 tb/tb_abm_combiner_axi.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abm_pkg.sv
// Shared encodings, FSM state types and sizing helpers for the ABM combiner.
package abm_pkg;

    // Combine operation applied across banks (3 is reserved and behaves as OR)
    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;

    // AXI burst types
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN, RD_ERR} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    // Beat FIFO must absorb every read in flight through the RAM plus the output stage
    function automatic int fifo_depth(input int ram_lat);
        return ram_lat + 2;
    endfunction

endpackage

// File: rtl/abm_beat_fifo.sv
// Small synchronous first-word-fall-through FIFO holding combined read beats.
module abm_beat_fifo #(
    parameter int W     = 513,
    parameter int DEPTH = 3,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [W-1:0]  din,
    input  logic          rd_en,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    // Storage array: written only, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/abm_combiner_axi.sv
// AXI4 read slave returning the bitwise OR/AND/XOR of one word across all RAM banks;
// writes are accepted and answered with SLVERR.
//
// Handshake rule used on every channel: a transfer happens on the rising clk edge
// where VALID and READY are both high; a source holds VALID and its payload stable
// until that edge, and never waits on READY before raising VALID.
module abm_combiner_axi
    import abm_pkg::*;
#(
    parameter int DW      = 512,
    parameter int DD      = 16384,
    parameter int NBANKS  = 2,
    parameter int RAM_LAT = 1,
    parameter int IDW     = 4,
    localparam int AW     = $clog2(DD * DW / 8),
    localparam int RAW    = $clog2(DD)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           mode,
    output logic [RAW-1:0]       ram_addr,
    output logic                 ram_rden,
    input  logic [NBANKS*DW-1:0] ram_rdata,
    input  logic [AW-1:0]        S_AXI_AWADDR,
    input  logic [IDW-1:0]       S_AXI_AWID,
    input  logic [7:0]           S_AXI_AWLEN,
    input  logic [2:0]           S_AXI_AWSIZE,
    input  logic [1:0]           S_AXI_AWBURST,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [DW-1:0]        S_AXI_WDATA,
    input  logic [DW/8-1:0]      S_AXI_WSTRB,
    input  logic                 S_AXI_WLAST,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    output logic [IDW-1:0]       S_AXI_BID,
    output logic [1:0]           S_AXI_BRESP,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    input  logic [AW-1:0]        S_AXI_ARADDR,
    input  logic [IDW-1:0]       S_AXI_ARID,
    input  logic [7:0]           S_AXI_ARLEN,
    input  logic [2:0]           S_AXI_ARSIZE,
    input  logic [1:0]           S_AXI_ARBURST,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    output logic [DW-1:0]        S_AXI_RDATA,
    output logic [IDW-1:0]       S_AXI_RID,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RLAST,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY,
    output rd_state_t            dbg_rd_state,
    output wr_state_t            dbg_wr_state
);

    localparam int DEPTH = fifo_depth(RAM_LAT);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int BSH   = $clog2(DW / 8);

    rd_state_t      rd_state, rd_next;
    wr_state_t      wr_state, wr_next;
    logic           up;            // low only in the first cycle after reset release
    logic [IDW-1:0] rid_q, bid_q;
    logic [7:0]     len_q, issue_cnt, beat_cnt;
    logic [1:0]     burst_q, mode_q;
    logic [RAW-1:0] addr_q;
    logic [CW-1:0]  credits;       // reads issued and not yet popped from the FIFO
    logic [RAM_LAT-1:0] pipe_v, pipe_last;
    logic [DW-1:0]  combined;
    logic [DW:0]    fifo_dout;
    logic           fifo_empty, pop, ar_hs, r_hs;
    logic [CW-1:0]  fifo_count;
    logic           unused_ok;

    assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs     = S_AXI_RVALID && S_AXI_RREADY;
    assign pop      = r_hs && (rd_state != RD_ERR);
    assign ram_addr = addr_q;
    assign dbg_rd_state = rd_state;
    assign dbg_wr_state = wr_state;
    assign unused_ok = ^{S_AXI_ARADDR[BSH-1:0], S_AXI_ARSIZE, S_AXI_AWADDR, S_AXI_AWLEN,
                         S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_WDATA, S_AXI_WSTRB, fifo_count};

    // Read FSM next state, RAM strobe and R channel outputs
    always_comb begin
        rd_next       = rd_state;
        S_AXI_ARREADY = up && (rd_state == RD_IDLE);
        ram_rden      = (rd_state == RD_ISSUE) && (credits < CW'(DEPTH));
        S_AXI_RVALID  = !fifo_empty;
        S_AXI_RDATA   = fifo_dout[DW-1:0];
        S_AXI_RLAST   = fifo_dout[DW];
        S_AXI_RRESP   = RESP_OKAY;
        S_AXI_RID     = rid_q;
        case (rd_state)
            RD_IDLE: if (ar_hs)
                rd_next = (S_AXI_ARBURST == BURST_FIXED || S_AXI_ARBURST == BURST_INCR)
                          ? RD_ISSUE : RD_ERR;
            RD_ISSUE: if (ram_rden && issue_cnt == len_q) rd_next = RD_DRAIN;
            RD_DRAIN: if (r_hs && S_AXI_RLAST) rd_next = RD_IDLE;
            RD_ERR: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RDATA  = '0;
                S_AXI_RLAST  = (beat_cnt == len_q);
                S_AXI_RRESP  = RESP_SLVERR;
                if (r_hs && S_AXI_RLAST) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read-side state, burst context, credit counter and RAM-latency tracking pipe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state  <= RD_IDLE;
            up        <= 1'b0;
            rid_q     <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            mode_q    <= '0;
            addr_q    <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            credits   <= '0;
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            up       <= 1'b1;
            rd_state <= rd_next;
            if (ar_hs) begin
                rid_q     <= S_AXI_ARID;
                len_q     <= S_AXI_ARLEN;
                burst_q   <= S_AXI_ARBURST;
                mode_q    <= mode;
                addr_q    <= S_AXI_ARADDR[AW-1:BSH];
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (ram_rden) begin
                    issue_cnt <= issue_cnt + 8'd1;
                    if (burst_q == BURST_INCR) addr_q <= addr_q + 1'b1;
                end
                if (r_hs) beat_cnt <= beat_cnt + 8'd1;
            end
            case ({ram_rden, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
            pipe_v[0]    <= ram_rden;
            pipe_last[0] <= ram_rden && (issue_cnt == len_q);
            for (int k = 1; k < RAM_LAT; k++) begin
                pipe_v[k]    <= pipe_v[k-1];
                pipe_last[k] <= pipe_last[k-1];
            end
        end
    end

    // Reduce all bank slices with the op latched at the AR handshake
    always_comb begin
        combined = ram_rdata[DW-1:0];
        for (int b = 1; b < NBANKS; b++) begin
            case (mode_q)
                MODE_AND: combined = combined & ram_rdata[b*DW +: DW];
                MODE_XOR: combined = combined ^ ram_rdata[b*DW +: DW];
                default:  combined = combined | ram_rdata[b*DW +: DW];
            endcase
        end
    end

    abm_beat_fifo #(.W(DW + 1), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (pipe_v[RAM_LAT-1]),
        .din    ({pipe_last[RAM_LAT-1], combined}),
        .rd_en  (pop),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Write FSM next state and outputs: every write is drained and refused
    always_comb begin
        wr_next       = wr_state;
        S_AXI_AWREADY = up && (wr_state == WR_IDLE);
        S_AXI_WREADY  = (wr_state == WR_DATA);
        S_AXI_BVALID  = (wr_state == WR_RESP);
        S_AXI_BRESP   = RESP_SLVERR;
        S_AXI_BID     = bid_q;
        case (wr_state)
            WR_IDLE: if (S_AXI_AWVALID && S_AXI_AWREADY) wr_next = WR_DATA;
            WR_DATA: if (S_AXI_WVALID && S_AXI_WLAST) wr_next = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write-side state and captured AWID
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state <= WR_IDLE;
            bid_q    <= '0;
        end else begin
            wr_state <= wr_next;
            if (S_AXI_AWVALID && S_AXI_AWREADY) bid_q <= S_AXI_AWID;
        end
    end

endmodule

// File: tb/tb_abm_combiner_axi.sv
// Directed bench for abm_combiner_axi with a behavioural two-bank RAM.
module tb_abm_combiner_axi;
    import abm_pkg::*;

    localparam int DW      = 512;
    localparam int DD      = 16384;
    localparam int NBANKS  = 2;
    localparam int RAM_LAT = 1;
    localparam int IDW     = 4;
    localparam int AW      = $clog2(DD * DW / 8);
    localparam int RAW     = $clog2(DD);
    localparam int DEPTH   = RAM_LAT + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [1:0]           mode;
    logic [RAW-1:0]       ram_addr;
    logic                 ram_rden;
    logic [NBANKS*DW-1:0] ram_rdata;
    logic [AW-1:0]        S_AXI_AWADDR, S_AXI_ARADDR;
    logic [IDW-1:0]       S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
    logic [7:0]           S_AXI_AWLEN, S_AXI_ARLEN;
    logic [2:0]           S_AXI_AWSIZE, S_AXI_ARSIZE;
    logic [1:0]           S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
    logic                 S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
    logic [DW-1:0]        S_AXI_WDATA, S_AXI_RDATA;
    logic [DW/8-1:0]      S_AXI_WSTRB;
    logic                 S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic                 S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
    rd_state_t            dbg_rd_state;
    wr_state_t            dbg_wr_state;

    abm_combiner_axi #(.DW(DW), .DD(DD), .NBANKS(NBANKS), .RAM_LAT(RAM_LAT), .IDW(IDW)) dut (
        .clk(clk), .resetn(resetn), .mode(mode),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_rdata(ram_rdata),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
    );

    // ---------------- RAM model and monitors ----------------
    logic [DW-1:0] bank0 [DD];
    logic [DW-1:0] bank1 [DD];

    always @(posedge clk) begin
        if (ram_rden) ram_rdata <= {bank1[ram_addr], bank0[ram_addr]};
    end

    int outst = 0, ovf_cnt = 0, rden_cnt = 0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst <= 0;
        end else begin
            if (outst + int'(ram_rden) - int'(S_AXI_RVALID && S_AXI_RREADY && S_AXI_RRESP == 2'd0) > DEPTH)
                ovf_cnt <= ovf_cnt + 1;
            outst <= outst + int'(ram_rden) - int'(S_AXI_RVALID && S_AXI_RREADY && S_AXI_RRESP == 2'd0);
            if (ram_rden) rden_cnt <= rden_cnt + 1;
        end
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0]  bd [$];
    logic           bl [$];
    logic [IDW-1:0] bi [$];
    logic [1:0]     br [$];
    int             bc [$];
    int             lat;
    logic [DW-1:0]  exp_q [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_ar(input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] md);
        int t = 0;
        while (!S_AXI_ARREADY && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ar_ready_wait", S_AXI_ARREADY, 1);
        S_AXI_ARADDR  = a;
        S_AXI_ARID    = id;
        S_AXI_ARLEN   = len;
        S_AXI_ARBURST = burst;
        S_AXI_ARSIZE  = 3'd6;
        mode          = md;
        S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
    endtask

    // Collects n R beats; cycle 1 is the first cycle after the AR handshake
    task automatic collect(input int n, input bit stall);
        int            cyc = 1;
        bit            hold = 0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        bd.delete(); bl.delete(); bi.delete(); br.delete(); bc.delete();
        lat = -1;
        while (bd.size() < n && cyc < 500) begin
            S_AXI_RREADY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold) begin
                check("stall_rvalid", S_AXI_RVALID, 1);
                check("stall_rdata", S_AXI_RDATA, held_d);
                check("stall_rlast", S_AXI_RLAST, held_l);
            end
            if (S_AXI_RVALID && lat < 0) lat = cyc;
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                bd.push_back(S_AXI_RDATA);
                bl.push_back(S_AXI_RLAST);
                bi.push_back(S_AXI_RID);
                br.push_back(S_AXI_RRESP);
                bc.push_back(cyc);
            end
            hold   = S_AXI_RVALID && !S_AXI_RREADY;
            held_d = S_AXI_RDATA;
            held_l = S_AXI_RLAST;
            @(negedge clk);
            cyc++;
        end
        S_AXI_RREADY = 1'b1;
        check("beat_count", bd.size(), n);
    endtask

    // Compares collected beats against exp_q and a single RLAST on the final beat
    task automatic score(input string tag, input logic [IDW-1:0] id, input logic [1:0] resp);
        int n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            check({tag, "_data"}, bd[k], exp_q[k]);
            check({tag, "_last"}, bl[k], (k == n - 1));
            check({tag, "_id"}, bi[k], id);
            check({tag, "_resp"}, br[k], resp);
        end
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int r0, o0, wcnt;
        resetn = 1'b0;
        mode = 2'd0;
        S_AXI_AWADDR = '0; S_AXI_AWID = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARID = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0;
        S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;

        for (int w = 10; w <= 13; w++) begin bank0[w] = 'h0F; bank1[w] = 'hF0; end
        bank0[DD-2] = 'hA0; bank1[DD-2] = 'h0A;
        bank0[DD-1] = 'hB0; bank1[DD-1] = 'h0B;
        bank0[0]    = 'hC0; bank1[0]    = 'h0C;
        bank0[1]    = 'hD0; bank1[1]    = 'h0D;
        bank0[7]    = 'h1234; bank1[7]  = 'h5600;
        for (int w = 100; w < 116; w++) begin bank0[w] = DW'(w); bank1[w] = DW'(w) << 8; end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_arready", S_AXI_ARREADY, 0);
        check("rst_awready", S_AXI_AWREADY, 0);
        check("rst_wready", S_AXI_WREADY, 0);
        check("rst_rvalid", S_AXI_RVALID, 0);
        check("rst_bvalid", S_AXI_BVALID, 0);
        check("rst_rden", ram_rden, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_rd_state", dbg_rd_state, RD_IDLE);
        resetn = 1'b1;
        #1;
        check("rel_arready_pre_clk", S_AXI_ARREADY, 0);
        @(negedge clk);
        check("rel_arready", S_AXI_ARREADY, 1);
        check("rel_awready", S_AXI_AWREADY, 1);

        // OR burst, LEN=3, ID=5
        r0 = rden_cnt;
        send_ar(AW'(10 * 64), 4'd5, 8'd3, BURST_INCR, MODE_OR);
        collect(4, 0);
        check("or_latency", lat, RAM_LAT + 2);
        check("or_back_to_back", bc[3] - bc[0], 3);
        check("or_rden_count", rden_cnt - r0, 4);
        check("or_arready_after", S_AXI_ARREADY, 1);
        repeat (4) exp_q.push_back('hFF);
        score("or", 4'd5, RESP_OKAY);

        // AND and XOR over the same words
        send_ar(AW'(10 * 64), 4'd1, 8'd3, BURST_INCR, MODE_AND);
        collect(4, 0);
        repeat (4) exp_q.push_back('h00);
        score("and", 4'd1, RESP_OKAY);
        send_ar(AW'(10 * 64), 4'd2, 8'd3, BURST_INCR, MODE_XOR);
        collect(4, 0);
        repeat (4) exp_q.push_back('hFF);
        score("xor", 4'd2, RESP_OKAY);

        // INCR wrapping past the top of the bank
        send_ar(AW'((DD - 2) * 64), 4'd7, 8'd3, BURST_INCR, MODE_OR);
        collect(4, 0);
        exp_q.push_back('hAA); exp_q.push_back('hBB);
        exp_q.push_back('hCC); exp_q.push_back('hDD);
        score("addr_wrap", 4'd7, RESP_OKAY);

        // Random RREADY backpressure over 16 beats
        r0 = rden_cnt;
        o0 = ovf_cnt;
        send_ar(AW'(100 * 64), 4'd9, 8'd15, BURST_INCR, MODE_OR);
        collect(16, 1);
        for (int w = 100; w < 116; w++) exp_q.push_back(DW'(w) | (DW'(w) << 8));
        score("stall", 4'd9, RESP_OKAY);
        check("stall_no_overflow", ovf_cnt - o0, 0);
        check("stall_rden_count", rden_cnt - r0, 16);

        // FIXED burst re-reads one word
        r0 = rden_cnt;
        send_ar(AW'(7 * 64), 4'd4, 8'd2, BURST_FIXED, MODE_OR);
        collect(3, 0);
        repeat (3) exp_q.push_back('h5634);
        score("fixed", 4'd4, RESP_OKAY);
        check("fixed_rden_count", rden_cnt - r0, 3);

        // WRAP burst answered with SLVERR zeros, no RAM access
        r0 = rden_cnt;
        send_ar(AW'(10 * 64), 4'd6, 8'd1, BURST_WRAP, MODE_OR);
        collect(2, 0);
        check("err_latency", lat, 1);
        repeat (2) exp_q.push_back('h0);
        score("err", 4'd6, RESP_SLVERR);
        check("err_rden_count", rden_cnt - r0, 0);

        // Simultaneous AR and AW, then the rejected write
        S_AXI_RREADY = 1'b0;
        check("both_arready", S_AXI_ARREADY, 1);
        check("both_awready", S_AXI_AWREADY, 1);
        S_AXI_ARADDR = AW'(7 * 64); S_AXI_ARID = 4'd2; S_AXI_ARLEN = 8'd0;
        S_AXI_ARBURST = BURST_FIXED; mode = MODE_OR; S_AXI_ARVALID = 1'b1;
        S_AXI_AWID = 4'd3; S_AXI_AWLEN = 8'd2; S_AXI_AWBURST = BURST_INCR; S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWVALID = 1'b0;
        check("both_arready_drop", S_AXI_ARREADY, 0);
        check("both_awready_drop", S_AXI_AWREADY, 0);
        check("w_wready_open", S_AXI_WREADY, 1);
        S_AXI_WVALID = 1'b1;
        wcnt = 0;
        for (int c = 0; c < 8; c++) begin
            S_AXI_WDATA = DW'($urandom);
            S_AXI_WLAST = (wcnt == 2);
            if (S_AXI_WREADY) wcnt++;
            @(negedge clk);
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        check("w_beats", wcnt, 3);
        check("w_wready_closed", S_AXI_WREADY, 0);
        check("b_valid", S_AXI_BVALID, 1);
        check("b_resp", S_AXI_BRESP, RESP_SLVERR);
        check("b_id", S_AXI_BID, 3);
        check("b_awready_held", S_AXI_AWREADY, 0);
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
        check("b_valid_drop", S_AXI_BVALID, 0);
        check("b_awready_back", S_AXI_AWREADY, 1);
        collect(1, 0);
        exp_q.push_back('h5634);
        score("parallel_rd", 4'd2, RESP_OKAY);

        // Reset in the middle of a burst
        send_ar(AW'(100 * 64), 4'd8, 8'd15, BURST_INCR, MODE_OR);
        repeat (5) @(negedge clk);
        check("mid_rvalid_pre", S_AXI_RVALID, 1);
        resetn = 1'b0;
        #1;
        check("mid_rvalid", S_AXI_RVALID, 0);
        check("mid_arready", S_AXI_ARREADY, 0);
        check("mid_rden", ram_rden, 0);
        check("mid_rd_state", dbg_rd_state, RD_IDLE);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("mid_arready_pre_clk", S_AXI_ARREADY, 0);
        @(negedge clk);
        check("mid_arready_post", S_AXI_ARREADY, 1);
        check("mid_rvalid_post", S_AXI_RVALID, 0);
        send_ar(AW'(10 * 64), 4'd6, 8'd3, BURST_INCR, MODE_OR);
        collect(4, 0);
        repeat (4) exp_q.push_back('hFF);
        score("post_rst", 4'd6, RESP_OKAY);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit in case the sequence itself wedges
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
